blob_bbox_tracker: RTL and testbench
====================================

Name: blob_bbox_tracker

Overview:
- Consumes the thresholded delta-frame pixel stream (all-ones = motion, all-zeros = static) one pixel per valid beat, raster order.
- Tracks motion-pixel coordinates and accumulates a per-frame bounding box, centroid and hot-pixel count.
- Publishes the results once per frame with a single-cycle strobe.
- Sits directly downstream of the delta stage and feeds the overlay/tracking-output logic.

Parameters:
- INPUT_WIDTH, 10, pixel width; must match the delta stage.
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- COORD_WIDTH, 10, coordinate width; must satisfy 2^COORD_WIDTH >= max(IMG_WIDTH, IMG_HEIGHT).
- COUNT_WIDTH, 19, hot-pixel counter width.
- MIN_PIXELS, 16, minimum hot pixels for object_found.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  tracking enable; same signal that puts the delta stage in threshold mode.
- in_valid  in  1  pixel beat valid.
- in_sof  in  1  start of frame; qualified by in_valid, marks pixel (0,0).
- in_pixel  in  INPUT_WIDTH  delta pixel; only the MSB is used (hot = MSB==1).
- out_valid  out  1  one-cycle publish strobe.
- object_found  out  1  pixel_count >= MIN_PIXELS.
- box_x_min, box_x_max  out  COORD_WIDTH  horizontal bounds.
- box_y_min, box_y_max  out  COORD_WIDTH  vertical bounds.
- centroid_x, centroid_y  out  COORD_WIDTH  box centre.
- pixel_count  out  COUNT_WIDTH  hot pixels in the frame.
- frame_error  out  1  one-cycle pulse on an early or duplicate sof.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: all outputs 0, FSM in WAIT_SOF, x/y counters 0, accumulators at their init values.
- Accumulator init values: mins all-ones, maxes 0, count 0.
- Beat: in_valid=1 while enable=1. Hot = beat AND in_pixel[INPUT_WIDTH-1].
- FSM states are WAIT_SOF, ACCUM and PUBLISH.
- WAIT_SOF:
  - Beats without in_sof are ignored.
  - A beat with in_sof is processed as pixel (0,0); accumulators restart from their init values plus that pixel. Next state is ACCUM.
- ACCUM, per beat:
  - x increments; at x==IMG_WIDTH-1, x wraps to 0 and y increments.
  - If hot: min/max updated with the current (x,y), and count increments, saturating at all-ones.
  - A beat at (IMG_WIDTH-1, IMG_HEIGHT-1) is processed, then next state is PUBLISH.
- ACCUM, in_sof on a beat:
  - frame_error pulses for 1 cycle.
  - The partial frame is discarded without a publish.
  - The beat is processed as (0,0) of a new frame; state stays ACCUM.
- PUBLISH (exactly one cycle):
  - Output registers load at the edge leaving PUBLISH. out_valid=1 for the following cycle only.
  - Latency: last pixel sampled at edge N; outputs and out_valid update at edge N+1.
  - A beat with in_sof during PUBLISH starts a new frame (next state ACCUM) and does not disturb the publish. Non-sof beats are ignored. Otherwise next state is WAIT_SOF.
- Published values:
  - object_found = (count >= MIN_PIXELS).
  - If found: box = accumulated min/max; centroid = (min+max)>>1, computed with a COORD_WIDTH+1-bit sum then truncated.
  - If not found: box and centroid outputs = 0.
  - pixel_count is always the accumulated count.
- Output hold: outputs other than the strobes hold until the next publish or reset.
- enable=0:
  - Beats are ignored. The FSM is forced to WAIT_SOF at the next edge, abandoning any partial frame with no frame_error.
  - Published outputs hold; out_valid=0.
- in_valid=0 cycles: no state change; counters freeze.
- Simultaneous reset and any input: reset wins.

Test Plan (bench parameters IMG_WIDTH=8, IMG_HEIGHT=6, MIN_PIXELS=2, enable=1 unless stated):
- Single 2x2 blob: hot pixels at (3,2),(4,2),(3,3),(4,3), otherwise cold, continuous beats → out_valid 1 cycle at edge after last pixel. Required: box 3..4 / 2..3, centroid (3,2), pixel_count=4, object_found=1.
- Empty frame: all cold → out_valid=1, object_found=0, box/centroid=0, pixel_count=0.
- Noise below MIN_PIXELS: one hot pixel at (7,5), which is also the last pixel → object_found=0, pixel_count=1, box=0. Publish still occurs.
- Early sof: sof again at beat 20 of frame A, then frame B with blob (0,0)-(1,1) → frame_error pulses once, no publish for A. B publishes box 0..1 / 0..1, count=4.
- Gapped valid plus back-to-back frames: random in_valid gaps, next sof during the PUBLISH cycle → two publishes with identical results for identical frames, none dropped.
- Mid-frame enable drop and reset: enable=0 at beat 10, re-enable, full frame → exactly one publish, for the full frame. Separately, assert reset mid-frame → all outputs 0 next cycle and the FSM waits for sof.

Source files
------------

// File: rtl/blob_bbox_tracker.sv
// blob_bbox_tracker
//   Tracks motion ("hot") pixels in a thresholded delta-frame raster stream and
//   publishes a per-frame bounding box, box centre and hot-pixel count.
//
//   Ports
//     clk, reset       : clock, synchronous active-high reset
//     enable           : tracking enable; beats are ignored while low
//     in_valid/in_sof  : pixel beat valid / start of frame (pixel 0,0)
//     in_pixel         : delta pixel, only the MSB is used (1 = hot)
//     out_valid        : one-cycle publish strobe
//     object_found     : pixel_count >= MIN_PIXELS
//     box_*            : bounding box (0 when no object)
//     centroid_x/_y    : box centre (0 when no object)
//     pixel_count      : hot pixels in the published frame
//     frame_error      : one-cycle pulse on an sof arriving mid-frame
module blob_bbox_tracker #(
    parameter int INPUT_WIDTH = 10,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int COORD_WIDTH = 10,
    parameter int COUNT_WIDTH = 19,
    parameter int MIN_PIXELS  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [INPUT_WIDTH-1:0] in_pixel,
    output logic                   out_valid,
    output logic                   object_found,
    output logic [COORD_WIDTH-1:0] box_x_min,
    output logic [COORD_WIDTH-1:0] box_x_max,
    output logic [COORD_WIDTH-1:0] box_y_min,
    output logic [COORD_WIDTH-1:0] box_y_max,
    output logic [COORD_WIDTH-1:0] centroid_x,
    output logic [COORD_WIDTH-1:0] centroid_y,
    output logic [COUNT_WIDTH-1:0] pixel_count,
    output logic                   frame_error
);

    localparam logic [1:0] WAIT_SOF = 2'd0;
    localparam logic [1:0] ACCUM    = 2'd1;
    localparam logic [1:0] PUBLISH  = 2'd2;

    localparam logic [COORD_WIDTH-1:0] X_LAST  = COORD_WIDTH'(IMG_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST  = COORD_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [COUNT_WIDTH-1:0] MIN_CNT = COUNT_WIDTH'(MIN_PIXELS);

    logic [1:0]             state_q, state_d;
    logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_WIDTH-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [COORD_WIDTH-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                   out_valid_q, out_valid_d, found_q, found_d, ferr_q, ferr_d;
    logic [COORD_WIDTH-1:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d;
    logic [COORD_WIDTH-1:0] bymin_q, bymin_d, bymax_q, bymax_d;
    logic [COORD_WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [COUNT_WIDTH-1:0] pcnt_q, pcnt_d;

    logic                   beat, hot, last, found;
    logic [COORD_WIDTH-1:0] cur_x, cur_y;
    logic [COORD_WIDTH:0]   sum_x, sum_y;

    // Only the pixel MSB carries information after thresholding.
    logic unused_pixel_bits;
    assign unused_pixel_bits = ^in_pixel[INPUT_WIDTH-2:0];

    assign beat  = in_valid & enable;
    assign hot   = beat & in_pixel[INPUT_WIDTH-1];
    // An sof beat is always pixel (0,0), whatever the counters say.
    assign cur_x = in_sof ? '0 : x_q;
    assign cur_y = in_sof ? '0 : y_q;
    assign last  = (cur_x == X_LAST) && (cur_y == Y_LAST);
    assign found = (cnt_q >= MIN_CNT);
    // One extra bit so the min+max sum cannot overflow before halving.
    assign sum_x = {1'b0, xmin_q} + {1'b0, xmax_q};
    assign sum_y = {1'b0, ymin_q} + {1'b0, ymax_q};

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        ferr_d      = 1'b0;
        found_d     = found_q;
        bxmin_d     = bxmin_q;
        bxmax_d     = bxmax_q;
        bymin_d     = bymin_q;
        bymax_d     = bymax_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        pcnt_d      = pcnt_q;

        // Publish reads the accumulator registers, so a new frame restarting
        // the accumulators in this same cycle cannot corrupt the result.
        if (enable && state_q == PUBLISH) begin
            out_valid_d = 1'b1;
            found_d     = found;
            pcnt_d      = cnt_q;
            bxmin_d     = found ? xmin_q : '0;
            bxmax_d     = found ? xmax_q : '0;
            bymin_d     = found ? ymin_q : '0;
            bymax_d     = found ? ymax_q : '0;
            cx_d        = found ? sum_x[COORD_WIDTH:1] : '0;
            cy_d        = found ? sum_y[COORD_WIDTH:1] : '0;
        end

        if (!enable) begin
            state_d = WAIT_SOF;
        end else if (beat && (in_sof || state_q == ACCUM)) begin
            ferr_d = in_sof && (state_q == ACCUM);
            if (in_sof) begin
                xmin_d = '1;
                xmax_d = '0;
                ymin_d = '1;
                ymax_d = '0;
                cnt_d  = '0;
            end
            if (hot) begin
                if (cur_x < xmin_d) xmin_d = cur_x;
                if (cur_x > xmax_d) xmax_d = cur_x;
                if (cur_y < ymin_d) ymin_d = cur_y;
                if (cur_y > ymax_d) ymax_d = cur_y;
                if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
            end
            if (last) begin
                x_d     = '0;
                y_d     = '0;
                state_d = PUBLISH;
            end else begin
                state_d = ACCUM;
                if (cur_x == X_LAST) begin
                    x_d = '0;
                    y_d = cur_y + 1'b1;
                end else begin
                    x_d = cur_x + 1'b1;
                    y_d = cur_y;
                end
            end
        end else if (state_q != ACCUM) begin
            state_d = WAIT_SOF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_SOF;
            x_q         <= '0;
            y_q         <= '0;
            xmin_q      <= '1;
            xmax_q      <= '0;
            ymin_q      <= '1;
            ymax_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ferr_q      <= 1'b0;
            found_q     <= 1'b0;
            bxmin_q     <= '0;
            bxmax_q     <= '0;
            bymin_q     <= '0;
            bymax_q     <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            pcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            ferr_q      <= ferr_d;
            found_q     <= found_d;
            bxmin_q     <= bxmin_d;
            bxmax_q     <= bxmax_d;
            bymin_q     <= bymin_d;
            bymax_q     <= bymax_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            pcnt_q      <= pcnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign object_found = found_q;
    assign box_x_min    = bxmin_q;
    assign box_x_max    = bxmax_q;
    assign box_y_min    = bymin_q;
    assign box_y_max    = bymax_q;
    assign centroid_x   = cx_q;
    assign centroid_y   = cy_q;
    assign pixel_count  = pcnt_q;
    assign frame_error  = ferr_q;

endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Scoreboard bench for blob_bbox_tracker on a small 8x6 image.
module tb_blob_bbox_tracker;

    localparam int IW   = 10;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int CW   = 10;
    localparam int NW   = 19;
    localparam int MINP = 2;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset, enable, in_valid, in_sof;
    logic [IW-1:0] in_pixel;
    logic          out_valid, object_found, frame_error;
    logic [CW-1:0] box_x_min, box_x_max, box_y_min, box_y_max, centroid_x, centroid_y;
    logic [NW-1:0] pixel_count;

    blob_bbox_tracker #(
        .INPUT_WIDTH(IW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
        .COORD_WIDTH(CW), .COUNT_WIDTH(NW), .MIN_PIXELS(MINP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_sof(in_sof), .in_pixel(in_pixel), .out_valid(out_valid),
        .object_found(object_found), .box_x_min(box_x_min), .box_x_max(box_x_max),
        .box_y_min(box_y_min), .box_y_max(box_y_max), .centroid_x(centroid_x),
        .centroid_y(centroid_y), .pixel_count(pixel_count), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int found, xmin, xmax, ymin, ymax, cx, cy, cnt;
    } res_t;

    res_t exp_q[$];
    int   lat_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fe_seen = 0;
    int   fe_exp = 0;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Reference: scan the whole frame map and summarise its hot pixels.
    function automatic res_t model(logic [NPIX-1:0] m);
        res_t r;
        int n = 0, x0 = W, x1 = -1, y0 = H, y1 = -1;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (m[y*W+x]) begin
                    n++;
                    if (x < x0) x0 = x;
                    if (x > x1) x1 = x;
                    if (y < y0) y0 = y;
                    if (y > y1) y1 = y;
                end
        r.cnt   = n;
        r.found = (n >= MINP) ? 1 : 0;
        if (r.found == 1) begin
            r.xmin = x0; r.xmax = x1; r.ymin = y0; r.ymax = y1;
            r.cx = (x0 + x1) / 2; r.cy = (y0 + y1) / 2;
        end else begin
            r.xmin = 0; r.xmax = 0; r.ymin = 0; r.ymax = 0; r.cx = 0; r.cy = 0;
        end
        return r;
    endfunction

    task automatic cycle(input bit v, input bit s, input bit hot);
        in_valid = v;
        in_sof   = s;
        in_pixel = IW'($urandom);
        in_pixel[IW-1] = hot;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Streams nbeats pixels of map m; gaps never precede the sof beat so that
    // consecutive frames land their sof in the publish cycle.
    task automatic send_frame(input logic [NPIX-1:0] m, input int nbeats,
                              input int gap_pct, input bit publish);
        if (publish) exp_q.push_back(model(m));
        for (int i = 0; i < nbeats; i++) begin
            if (i > 0)
                while ($urandom_range(99) < gap_pct)
                    cycle(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            cycle(1'b1, i == 0, m[i]);
        end
        if (publish) lat_q.push_back(cyc + 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_object_found"}, int'(object_found), 0);
        chk({tag, "_box_x_min"}, int'(box_x_min), 0);
        chk({tag, "_box_x_max"}, int'(box_x_max), 0);
        chk({tag, "_box_y_min"}, int'(box_y_min), 0);
        chk({tag, "_box_y_max"}, int'(box_y_max), 0);
        chk({tag, "_centroid_x"}, int'(centroid_x), 0);
        chk({tag, "_centroid_y"}, int'(centroid_y), 0);
        chk({tag, "_pixel_count"}, int'(pixel_count), 0);
        chk({tag, "_frame_error"}, int'(frame_error), 0);
    endtask

    function automatic logic [NPIX-1:0] rand_map(input int pct);
        logic [NPIX-1:0] m;
        for (int i = 0; i < NPIX; i++) m[i] = ($urandom_range(99) < pct);
        return m;
    endfunction

    // Monitor: compares each publish against the oldest queued expectation.
    always @(negedge clk) begin
        if (frame_error) fe_seen++;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL publish_expected actual=unexpected out_valid required=no publish");
            end else begin
                res_t r;
                r = exp_q.pop_front();
                chk("object_found", int'(object_found), r.found);
                chk("box_x_min", int'(box_x_min), r.xmin);
                chk("box_x_max", int'(box_x_max), r.xmax);
                chk("box_y_min", int'(box_y_min), r.ymin);
                chk("box_y_max", int'(box_y_max), r.ymax);
                chk("centroid_x", int'(centroid_x), r.cx);
                chk("centroid_y", int'(centroid_y), r.cy);
                chk("pixel_count", int'(pixel_count), r.cnt);
            end
            if (lat_q.size() != 0) chk("publish_cycle", cyc, lat_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NPIX-1:0] m, m2;
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // 2x2 blob at (3..4, 2..3)
        m = '0; m[19] = 1'b1; m[20] = 1'b1; m[27] = 1'b1; m[28] = 1'b1;
        send_frame(m, NPIX, 0, 1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // empty frame
        send_frame('0, NPIX, 0, 1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // single hot pixel at the very last position
        m = '0; m[NPIX-1] = 1'b1;
        send_frame(m, NPIX, 0, 1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // early sof: frame A abandoned at beat 20, frame B blob (0..1, 0..1)
        send_frame(rand_map(50), 20, 0, 0);
        fe_exp++;
        m = '0; m[0] = 1'b1; m[1] = 1'b1; m[8] = 1'b1; m[9] = 1'b1;
        send_frame(m, NPIX, 0, 1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        chk("frame_error_after_early_sof", fe_seen, fe_exp);

        // gapped identical frames, back to back
        m = rand_map(20);
        send_frame(m, NPIX, 30, 1);
        send_frame(m, NPIX, 30, 1);
        // random back-to-back frames of varying density
        for (int f = 0; f < 4; f++) begin
            m2 = rand_map((f == 0) ? 2 : 10 * f);
            send_frame(m2, NPIX, 25, 1);
        end
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // enable drop mid-frame, sof beats while disabled are ignored
        send_frame(rand_map(40), 10, 0, 0);
        enable = 1'b0;
        repeat (4) cycle(1'b1, 1'b1, 1'b1);
        enable = 1'b1;
        send_frame(rand_map(30), NPIX, 0, 1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // reset mid-frame, then non-sof beats must be ignored
        send_frame(rand_map(40), 15, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("midreset");
        for (int i = 0; i < NPIX + 4; i++) cycle(1'b1, 1'b0, 1'b1);
        send_frame(rand_map(35), NPIX, 10, 1);

        repeat (6) cycle(1'b0, 1'b0, 1'b0);
        chk("pending_publishes", exp_q.size(), 0);
        chk("frame_error_cycles", fe_seen, fe_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
